islem_denetleyici: RTL and testbench

//  Sequences and shares the calculator's multi-cycle arithmetic units (toplama, cikarma, carpma, bolme).

---
 rtl/islem_denetleyici.sv | 158 +++++++++++++++
 tb/tb_islem_denetleyici.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/islem_denetleyici.sv
// Operation sequencer: takes one request, starts the selected arithmetic unit,
// waits for its done pulse (or a timeout) and hands the result to the consumer.
module islem_denetleyici #(
    parameter int ISLEM_SAYISI = 4,
    parameter int ZAMAN_ASIMI  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      istek_gecerli,
    output logic                      istek_hazir,
    input  logic [2:0]                islem_kodu,
    input  logic [31:0]               sayi1,
    input  logic [31:0]               sayi2,
    output logic [ISLEM_SAYISI-1:0]   birim_basla,
    output logic [31:0]               birim_sayi1,
    output logic [31:0]               birim_sayi2,
    input  logic [ISLEM_SAYISI-1:0]   birim_bitti,
    input  logic [64*ISLEM_SAYISI-1:0] birim_sonuc,
    input  logic [ISLEM_SAYISI-1:0]   birim_tasma,
    output logic [63:0]               sonuc,
    output logic                      sonuc_gecerli,
    input  logic                      sonuc_hazir,
    output logic                      tasma,
    output logic                      hata,
    output logic                      mesgul,
    output logic [15:0]               islem_sayaci
);

    localparam int SW = $clog2(ZAMAN_ASIMI + 1);

    typedef enum logic [1:0] {BOS, BASLAT, BEKLE, TESLIM} durum_t;

    durum_t            durum_q, durum_d;
    logic [2:0]        kod_q, kod_d;
    logic [31:0]       s1_q, s1_d;
    logic [31:0]       s2_q, s2_d;
    logic [63:0]       sonuc_q, sonuc_d;
    logic              tasma_q, tasma_d;
    logic              hata_q, hata_d;
    logic [SW-1:0]     sayac_q, sayac_d;
    logic [15:0]       islem_sayaci_q, islem_sayaci_d;

    logic              sec_bitti;
    logic              sec_tasma;
    logic [63:0]       sec_sonuc;
    logic [ISLEM_SAYISI-1:0] basla_kod;
    logic              kod_gecerli;

    // Only the latched unit's done/result/overflow lines are ever looked at.
    always_comb begin
        sec_bitti = 1'b0;
        sec_tasma = 1'b0;
        sec_sonuc = '0;
        basla_kod = '0;
        for (int k = 0; k < ISLEM_SAYISI; k++) begin
            if (kod_q == 3'(k)) begin
                sec_bitti    = birim_bitti[k];
                sec_tasma    = birim_tasma[k];
                sec_sonuc    = birim_sonuc[64*k +: 64];
                basla_kod[k] = 1'b1;
            end
        end
    end

    assign kod_gecerli = {1'b0, islem_kodu} < 4'(ISLEM_SAYISI);

    always_comb begin
        durum_d        = durum_q;
        kod_d          = kod_q;
        s1_d           = s1_q;
        s2_d           = s2_q;
        sonuc_d        = sonuc_q;
        tasma_d        = tasma_q;
        hata_d         = hata_q;
        sayac_d        = sayac_q;
        islem_sayaci_d = islem_sayaci_q;
        unique case (durum_q)
            BOS: begin
                if (istek_gecerli) begin
                    kod_d = islem_kodu;
                    s1_d  = sayi1;
                    s2_d  = sayi2;
                    if (kod_gecerli) begin
                        durum_d = BASLAT;
                    end else begin
                        sonuc_d = '0;
                        tasma_d = 1'b0;
                        hata_d  = 1'b1;
                        durum_d = TESLIM;
                    end
                end
            end
            BASLAT: begin
                sayac_d = '0;
                durum_d = BEKLE;
            end
            BEKLE: begin
                // A done pulse on the last allowed cycle still beats the timeout.
                if (sec_bitti) begin
                    sonuc_d = sec_sonuc;
                    tasma_d = sec_tasma;
                    hata_d  = 1'b0;
                    durum_d = TESLIM;
                end else if (sayac_q == SW'(ZAMAN_ASIMI - 1)) begin
                    sonuc_d = '0;
                    tasma_d = 1'b0;
                    hata_d  = 1'b1;
                    durum_d = TESLIM;
                end else begin
                    sayac_d = sayac_q + SW'(1);
                end
            end
            TESLIM: begin
                if (sonuc_hazir) begin
                    islem_sayaci_d = islem_sayaci_q + 16'd1;
                    durum_d        = BOS;
                end
            end
            default: durum_d = BOS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q        <= BOS;
            kod_q          <= '0;
            s1_q           <= '0;
            s2_q           <= '0;
            sonuc_q        <= '0;
            tasma_q        <= 1'b0;
            hata_q         <= 1'b0;
            sayac_q        <= '0;
            islem_sayaci_q <= '0;
        end else begin
            durum_q        <= durum_d;
            kod_q          <= kod_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            sonuc_q        <= sonuc_d;
            tasma_q        <= tasma_d;
            hata_q         <= hata_d;
            sayac_q        <= sayac_d;
            islem_sayaci_q <= islem_sayaci_d;
        end
    end

    assign istek_hazir   = !rst && (durum_q == BOS);
    assign birim_basla   = (!rst && durum_q == BASLAT) ? basla_kod : '0;
    assign birim_sayi1   = s1_q;
    assign birim_sayi2   = s2_q;
    assign sonuc         = sonuc_q;
    assign sonuc_gecerli = (durum_q == TESLIM);
    assign tasma         = tasma_q;
    assign hata          = hata_q;
    assign mesgul        = (durum_q != BOS);
    assign islem_sayaci  = islem_sayaci_q;

endmodule

// File: tb/tb_islem_denetleyici.sv
// Scoreboard bench for islem_denetleyici with delay-programmable unit models
// (add, subtract, multiply, divide) and a stray done-pulse injector.
module tb_islem_denetleyici;

    localparam int N  = 4;
    localparam int ZA = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              istek_gecerli;
    logic              istek_hazir;
    logic [2:0]        islem_kodu;
    logic [31:0]       sayi1;
    logic [31:0]       sayi2;
    logic [N-1:0]      birim_basla;
    logic [31:0]       birim_sayi1;
    logic [31:0]       birim_sayi2;
    logic [N-1:0]      birim_bitti;
    logic [64*N-1:0]   birim_sonuc;
    logic [N-1:0]      birim_tasma;
    logic [63:0]       sonuc;
    logic              sonuc_gecerli;
    logic              sonuc_hazir;
    logic              tasma;
    logic              hata;
    logic              mesgul;
    logic [15:0]       islem_sayaci;

    always #5 clk = ~clk;

    islem_denetleyici #(.ISLEM_SAYISI(N), .ZAMAN_ASIMI(ZA)) dut (
        .clk(clk), .rst(rst),
        .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir),
        .islem_kodu(islem_kodu), .sayi1(sayi1), .sayi2(sayi2),
        .birim_basla(birim_basla),
        .birim_sayi1(birim_sayi1), .birim_sayi2(birim_sayi2),
        .birim_bitti(birim_bitti), .birim_sonuc(birim_sonuc),
        .birim_tasma(birim_tasma),
        .sonuc(sonuc), .sonuc_gecerli(sonuc_gecerli),
        .sonuc_hazir(sonuc_hazir), .tasma(tasma), .hata(hata),
        .mesgul(mesgul), .islem_sayaci(islem_sayaci)
    );

    typedef struct packed {
        logic [63:0] sonuc;
        logic        tasma;
        logic        hata;
    } beklenen_t;

    int          test_say = 0;
    int          hata_say = 0;
    beklenen_t   sb_q[$];
    int          gecikme[N];
    int          kalan[N];
    int          basla_say = 0;
    int          cikis_say = 0;
    logic [N-1:0] model_bitti = '0;
    logic [N-1:0] ek_bitti = '0;

    task automatic kontrol(input string etiket,
                           input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        test_say++;
        if (gozlenen !== beklenen) begin
            hata_say++;
            $display("FAIL %s: got %h, want %h", etiket, gozlenen, beklenen);
        end
    endtask

    logic [63:0] toplam;
    assign toplam = {32'h0, birim_sayi1} + {32'h0, birim_sayi2};
    assign birim_sonuc[63:0]    = toplam;
    assign birim_sonuc[127:64]  = {32'h0, birim_sayi1} - {32'h0, birim_sayi2};
    assign birim_sonuc[191:128] = {32'h0, birim_sayi1} * {32'h0, birim_sayi2};
    assign birim_sonuc[255:192] = (birim_sayi2 == 32'h0) ? 64'h0 :
                                  {32'h0, birim_sayi1 / birim_sayi2};
    assign birim_tasma = {3'b000, toplam[32]};
    assign birim_bitti = model_bitti | ek_bitti;

    // Unit k pulses done gecikme[k] cycles after its start; 0 = never answers.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            model_bitti[k] = 1'b0;
            if (kalan[k] > 0) begin
                kalan[k] = kalan[k] - 1;
                if (kalan[k] == 0) model_bitti[k] = 1'b1;
            end
            if (birim_basla[k]) begin
                kalan[k] = gecikme[k];
                basla_say++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && sonuc_gecerli && sonuc_hazir) begin
            if (sb_q.size() == 0) begin
                kontrol("sb_empty", 64'd1, 64'd0);
            end else begin
                beklenen_t b;
                b = sb_q.pop_front();
                kontrol("sonuc", sonuc, b.sonuc);
                kontrol("tasma", 64'(tasma), 64'(b.tasma));
                kontrol("hata", 64'(hata), 64'(b.hata));
            end
            cikis_say++;
        end
    end

    function automatic beklenen_t hesapla(input logic [2:0] kod,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        beklenen_t r;
        logic [63:0] t;
        r.sonuc = '0;
        r.tasma = 1'b0;
        r.hata  = 1'b1;
        if (int'(kod) < N && gecikme[kod] >= 1 && gecikme[kod] <= ZA) begin
            r.hata = 1'b0;
            case (kod)
                3'd0: begin
                    t       = {32'h0, a} + {32'h0, b};
                    r.sonuc = t;
                    r.tasma = t[32];
                end
                3'd1: r.sonuc = {32'h0, a} - {32'h0, b};
                3'd2: r.sonuc = {32'h0, a} * {32'h0, b};
                default: r.sonuc = {32'h0, a / b};
            endcase
        end
        return r;
    endfunction

    task automatic istek_gonder(input logic [2:0] kod,
                                input logic [31:0] a,
                                input logic [31:0] b);
        int n;
        n = 0;
        islem_kodu    = kod;
        sayi1         = a;
        sayi2         = b;
        istek_gecerli = 1'b1;
        @(negedge clk);
        while (!istek_hazir && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!istek_hazir) kontrol("req_timeout", 64'd0, 64'd1);
        else sb_q.push_back(hesapla(kod, a, b));
        @(posedge clk);
        #1 istek_gecerli = 1'b0;
    endtask

    task automatic bekle_cikis(input int hedef);
        int n;
        n = 0;
        while (cikis_say < hedef && n < 500) begin
            @(negedge clk);
            n++;
        end
        kontrol("out_count", 64'(cikis_say), 64'(hedef));
        @(posedge clk);
        #1;
    endtask

    int b0;
    int n;

    initial begin
        rst           = 1'b1;
        istek_gecerli = 1'b0;
        islem_kodu    = '0;
        sayi1         = '0;
        sayi2         = '0;
        sonuc_hazir   = 1'b1;
        gecikme       = '{5, 33, 0, 7};
        kalan         = '{default: 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        kontrol("rst_hazir", 64'(istek_hazir), 64'd0);
        kontrol("rst_basla", 64'(birim_basla), 64'd0);
        kontrol("rst_gecerli", 64'(sonuc_gecerli), 64'd0);
        kontrol("rst_mesgul", 64'(mesgul), 64'd0);
        kontrol("rst_sayac", 64'(islem_sayaci), 64'd0);
        kontrol("rst_sonuc", sonuc, 64'd0);
        kontrol("rst_hata", 64'(hata), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        kontrol("post_rst_hazir", 64'(istek_hazir), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a wait
        istek_gonder(3'd1, 32'd10, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        kontrol("t1_mesgul", 64'(mesgul), 64'd1);
        b0 = basla_say;
        @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        kontrol("t1_hazir_forced", 64'(istek_hazir), 64'd0);
        kontrol("t1_basla_forced", 64'(birim_basla), 64'd0);
        @(negedge clk);
        kontrol("t1_mesgul_rst", 64'(mesgul), 64'd0);
        kontrol("t1_gecerli_rst", 64'(sonuc_gecerli), 64'd0);
        kontrol("t1_sonuc_rst", sonuc, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        kontrol("t1_hazir_after", 64'(istek_hazir), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        kontrol("t1_no_basla", 64'(basla_say), 64'(b0));
        kontrol("t1_no_output", 64'(cikis_say), 64'd0);
        kontrol("t1_sayac", 64'(islem_sayaci), 64'd0);

        // Basic subtract
        b0 = basla_say;
        istek_gonder(3'd1, 32'd10, 32'd3);
        @(negedge clk);
        kontrol("t2_basla", 64'(birim_basla), 64'b0010);
        bekle_cikis(1);
        kontrol("t2_basla_once", 64'(basla_say), 64'(b0 + 1));
        kontrol("t2_sayac", 64'(islem_sayaci), 64'd1);

        // Back-pressure with a pending request
        sonuc_hazir = 1'b0;
        istek_gonder(3'd1, 32'd10, 32'd3);
        islem_kodu    = 3'd0;
        sayi1         = 32'd5;
        sayi2         = 32'd9;
        istek_gecerli = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sonuc_gecerli && n < 100);
        kontrol("t3_gecerli", 64'(sonuc_gecerli), 64'd1);
        repeat (5) begin
            kontrol("t3_stable", sonuc, 64'h7);
            kontrol("t3_hazir_low", 64'(istek_hazir), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 sonuc_hazir = 1'b1;
        @(negedge clk);
        kontrol("t3_hs_cycle_hazir", 64'(istek_hazir), 64'd0);
        @(negedge clk);
        kontrol("t3_accept_hazir", 64'(istek_hazir), 64'd1);
        sb_q.push_back(hesapla(3'd0, 32'd5, 32'd9));
        @(posedge clk);
        #1 istek_gecerli = 1'b0;
        @(negedge clk);
        kontrol("t3_basla", 64'(birim_basla), 64'b0001);
        bekle_cikis(3);
        kontrol("t3_sayac", 64'(islem_sayaci), 64'd3);

        // Timeout, done on the expiry cycle, done one cycle too late
        istek_gonder(3'd2, 32'd6, 32'd7);
        @(negedge clk);
        kontrol("t4_basla", 64'(birim_basla), 64'b0100);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sonuc_gecerli && n < 200);
        kontrol("t4_timeout_cycles", 64'(n), 64'd65);
        bekle_cikis(4);
        gecikme[2] = 64;
        istek_gonder(3'd2, 32'h0001_0000, 32'h0001_0000);
        bekle_cikis(5);
        gecikme[2] = 65;
        istek_gonder(3'd2, 32'd3, 32'd4);
        bekle_cikis(6);

        // Illegal opcodes and a stray done pulse
        b0 = basla_say;
        istek_gonder(3'd5, 32'd1, 32'd2);
        @(negedge clk);
        kontrol("t5_gecerli", 64'(sonuc_gecerli), 64'd1);
        kontrol("t5_hata", 64'(hata), 64'd1);
        bekle_cikis(7);
        istek_gonder(3'd7, 32'd1, 32'd2);
        bekle_cikis(8);
        kontrol("t5_no_basla", 64'(basla_say), 64'(b0));
        gecikme[0] = 20;
        istek_gonder(3'd0, 32'hFFFF_FFFF, 32'd2);
        repeat (5) @(posedge clk);
        #1 ek_bitti = 4'b1000;
        @(posedge clk);
        #1 ek_bitti = 4'b0000;
        repeat (3) @(negedge clk);
        kontrol("t5_stray_mesgul", 64'(mesgul), 64'd1);
        kontrol("t5_stray_gecerli", 64'(sonuc_gecerli), 64'd0);
        bekle_cikis(9);

        // Counter wrap
        @(posedge clk);
        #1 dut.islem_sayaci_q = 16'hFFFF;
        istek_gonder(3'd3, 32'd100, 32'd7);
        bekle_cikis(10);
        kontrol("t6_wrap", 64'(islem_sayaci), 64'd0);
        kontrol("sb_leftover", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_say, hata_say);
        $finish;
    end

endmodule
